// File: rtl/pwm_sar_adc.sv
`default_nettype none
// ============================================================================
// Module   : pwm_sar_adc
// Purpose  : 8-bit successive-approximation ADC built from a PWM DAC and an
//            external comparator, with block averaging and mV scaling.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_sar_adc #(
    parameter int SETTLE_PERIODS = 16,
    parameter int AVG_LOG2       = 4,
    parameter int VREF_MV        = 3300
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        comp_in,
    output logic        pwm_out,
    output logic [7:0]  raw8,
    output logic        raw_valid,
    output logic [7:0]  avg8,
    output logic [15:0] mv16,
    output logic        avg_valid
);

    localparam int c_PCNT_W = (SETTLE_PERIODS > 1) ? $clog2(SETTLE_PERIODS) : 1;
    localparam int c_ACC_W  = 8 + AVG_LOG2;
    localparam int c_N_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [c_PCNT_W-1:0] c_PCNT_LAST = c_PCNT_W'(SETTLE_PERIODS - 1);
    localparam logic [c_N_W-1:0]    c_N_LAST    = c_N_W'((1 << AVG_LOG2) - 1);
    localparam logic [15:0]         c_VREF      = 16'(VREF_MV);
    localparam logic [7:0]          c_DUTY_MSB  = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                r_state;
    logic [1:0]            r_sync;
    logic [7:0]            r_cnt;
    logic [7:0]            r_duty;
    logic [7:0]            r_result;
    logic [2:0]            r_bit;
    logic [c_PCNT_W-1:0]   r_pcnt;
    logic [c_ACC_W-1:0]    r_acc;
    logic [c_N_W-1:0]      r_n;

    logic                  w_comp_s;
    logic [7:0]            w_kept;
    logic [7:0]            w_next_duty;
    logic [c_ACC_W-1:0]    w_sum;
    logic [7:0]            w_avg;
    logic [23:0]           w_mv_prod;
    logic                  w_block_end;

    assign w_comp_s    = r_sync[1];
    // Trial bit survives only when the input is at or above the trial voltage.
    assign w_kept      = w_comp_s ? (r_result | (8'h01 << r_bit)) : r_result;
    assign w_next_duty = w_kept | (8'h01 << (r_bit - 3'd1));
    assign w_sum       = r_acc + c_ACC_W'(w_kept);
    assign w_avg       = 8'(w_sum >> AVG_LOG2);
    assign w_mv_prod   = 24'(w_avg) * 24'(c_VREF);
    assign w_block_end = (r_n == c_N_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_sync    <= 2'b00;
            r_cnt     <= 8'h00;
            r_duty    <= 8'h00;
            r_result  <= 8'h00;
            r_bit     <= 3'd7;
            r_pcnt    <= '0;
            r_acc     <= '0;
            r_n       <= '0;
            pwm_out   <= 1'b0;
            raw8      <= 8'h00;
            raw_valid <= 1'b0;
            avg8      <= 8'h00;
            mv16      <= 16'h0000;
            avg_valid <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], comp_in};
            raw_valid <= 1'b0;
            avg_valid <= 1'b0;
            if (!enable) begin
                r_state  <= ST_IDLE;
                r_cnt    <= 8'h00;
                r_duty   <= 8'h00;
                r_result <= 8'h00;
                r_bit    <= 3'd7;
                r_pcnt   <= '0;
                r_acc    <= '0;
                r_n      <= '0;
                pwm_out  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state  <= ST_CONVERT;
                        r_cnt    <= 8'h00;
                        r_duty   <= c_DUTY_MSB;
                        r_result <= 8'h00;
                        r_bit    <= 3'd7;
                        r_pcnt   <= '0;
                        pwm_out  <= 1'b0;
                    end
                    ST_CONVERT: begin
                        r_cnt   <= r_cnt + 8'd1;
                        pwm_out <= (r_cnt < r_duty);
                        if (r_cnt == 8'hFF) begin
                            if (r_pcnt == c_PCNT_LAST) begin
                                r_pcnt   <= '0;
                                r_result <= w_kept;
                                if (r_bit != 3'd0) begin
                                    r_duty <= w_next_duty;
                                    r_bit  <= r_bit - 3'd1;
                                end else begin
                                    // Next conversion's MSB trial starts on this wrap.
                                    r_duty    <= c_DUTY_MSB;
                                    r_state   <= ST_DONE;
                                    raw8      <= w_kept;
                                    raw_valid <= 1'b1;
                                    if (w_block_end) begin
                                        avg8      <= w_avg;
                                        mv16      <= 16'(w_mv_prod >> 8);
                                        avg_valid <= 1'b1;
                                        r_acc     <= '0;
                                        r_n       <= '0;
                                    end else begin
                                        r_acc <= w_sum;
                                        r_n   <= r_n + 1'b1;
                                    end
                                end
                            end else begin
                                r_pcnt <= r_pcnt + 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        r_cnt    <= r_cnt + 8'd1;
                        pwm_out  <= (r_cnt < r_duty);
                        r_state  <= ST_CONVERT;
                        r_result <= 8'h00;
                        r_bit    <= 3'd7;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        pwm_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_sar_adc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pwm_sar_adc
// Purpose  : Directed self-checking bench for pwm_sar_adc with an ideal
//            comparator model (input code >= current duty).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_sar_adc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic en_m, en_a2, en_a0;
    logic [7:0] vin_m, vin_a2, vin_a0;
    logic comp_m, comp_a2, comp_a0;

    logic        pwm_m, rv_m, av_m;
    logic [7:0]  raw_m, avg_m;
    logic [15:0] mv_m;
    logic        pwm_a2, rv_a2, av_a2;
    logic [7:0]  raw_a2, avg_a2;
    logic [15:0] mv_a2;
    logic        pwm_a0, rv_a0, av_a0;
    logic [7:0]  raw_a0, avg_a0;
    logic [15:0] mv_a0;

    pwm_sar_adc #(.SETTLE_PERIODS(1), .AVG_LOG2(4), .VREF_MV(3300)) u_dut (
        .clk(clk), .reset(reset), .enable(en_m), .comp_in(comp_m),
        .pwm_out(pwm_m), .raw8(raw_m), .raw_valid(rv_m),
        .avg8(avg_m), .mv16(mv_m), .avg_valid(av_m));

    pwm_sar_adc #(.SETTLE_PERIODS(1), .AVG_LOG2(2), .VREF_MV(3300)) u_dut_a2 (
        .clk(clk), .reset(reset), .enable(en_a2), .comp_in(comp_a2),
        .pwm_out(pwm_a2), .raw8(raw_a2), .raw_valid(rv_a2),
        .avg8(avg_a2), .mv16(mv_a2), .avg_valid(av_a2));

    pwm_sar_adc #(.SETTLE_PERIODS(1), .AVG_LOG2(0), .VREF_MV(3300)) u_dut_a0 (
        .clk(clk), .reset(reset), .enable(en_a0), .comp_in(comp_a0),
        .pwm_out(pwm_a0), .raw8(raw_a0), .raw_valid(rv_a0),
        .avg8(avg_a0), .mv16(mv_a0), .avg_valid(av_a0));

    // Ideal comparator against the DAC level the filter would settle to.
    assign comp_m  = (vin_m  >= u_dut.r_duty);
    assign comp_a2 = (vin_a2 >= u_dut_a2.r_duty);
    assign comp_a0 = (vin_a0 >= u_dut_a0.r_duty);

    int n_checks = 0;
    int n_errors = 0;
    int rv_cnt_m = 0;

    always @(negedge clk) if (rv_m) rv_cnt_m++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_duty [8];
        int hi;
        int rv0;
        exp_duty = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        reset = 1'b0;
        en_m = 1'b0; en_a2 = 1'b0; en_a0 = 1'b0;
        vin_m = 8'h00; vin_a2 = 8'h00; vin_a0 = 8'h00;

        tick(3);
        check("reset_pwm", pwm_m, 0);
        check("reset_raw8", raw_m, 0);
        check("reset_mv16", mv_m, 0);
        reset = 1'b1;
        tick(20);
        check("idle_pwm", pwm_m, 0);
        check("idle_raw_valid", rv_m, 0);

        // Single conversion of 0xA5 with trial-duty walk
        vin_m = 8'hA5;
        rv0 = rv_cnt_m;
        en_m = 1'b1;
        tick(1);
        for (int k = 0; k < 8; k++) begin
            check("duty_seq", u_dut.r_duty, exp_duty[k]);
            tick(256);
        end
        check("a5_raw_valid", rv_m, 1);
        check("a5_raw8", raw_m, 8'hA5);
        check("a5_avg_valid", av_m, 0);
        check("a5_early_pulses", rv_cnt_m - rv0, 0);

        // Back-to-back conversions: full-scale endpoints
        vin_m = 8'h00;
        tick(1);
        check("raw_valid_width", rv_m, 0);
        check("a5_pulse_count", rv_cnt_m - rv0, 1);
        tick(2047);
        check("zero_raw_valid", rv_m, 1);
        check("zero_raw8", raw_m, 8'h00);
        vin_m = 8'hFF;
        tick(7 * 256);
        check("ff_last_duty", u_dut.r_duty, 8'hFF);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            tick(1);
            hi += int'(pwm_m);
        end
        check("ff_pwm_high_count", hi, 255);
        check("ff_raw8", raw_m, 8'hFF);
        check("ff_raw_valid", rv_m, 1);

        // Asynchronous reset in the middle of a conversion
        tick(400);
        check("pre_reset_pwm", pwm_m, 1);
        #3 reset = 1'b0;
        #1;
        check("async_reset_raw8", raw_m, 0);
        check("async_reset_pwm", pwm_m, 0);
        en_m = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        rv0 = rv_cnt_m;
        tick(300);
        check("post_reset_raw8", raw_m, 0);
        check("post_reset_pwm", pwm_m, 0);
        check("post_reset_pulses", rv_cnt_m - rv0, 0);

        // Abort by dropping enable, then restart
        vin_m = 8'h3C;
        en_m = 1'b1;
        tick(2049);
        check("c3_raw8", raw_m, 8'h3C);
        check("c3_raw_valid", rv_m, 1);
        vin_m = 8'h5A;
        tick(800);
        check("pre_abort_pwm", pwm_m, 1);
        rv0 = rv_cnt_m;
        en_m = 1'b0;
        tick(1);
        check("abort_pwm", pwm_m, 0);
        tick(300);
        check("abort_raw8_hold", raw_m, 8'h3C);
        check("abort_pulses", rv_cnt_m - rv0, 0);
        en_m = 1'b1;
        tick(2048);
        check("restart_not_yet", rv_m, 0);
        tick(1);
        check("restart_raw_valid", rv_m, 1);
        check("restart_raw8", raw_m, 8'h5A);
        en_m = 1'b0;
        tick(1);
        check("restart_pulses", rv_cnt_m - rv0, 1);

        // Four-conversion average block
        vin_a2 = 8'h10;
        en_a2 = 1'b1;
        tick(2049);
        check("a2_raw1", raw_a2, 8'h10);
        check("a2_avg_valid1", av_a2, 0);
        vin_a2 = 8'h20;
        tick(2048);
        vin_a2 = 8'h30;
        tick(2048);
        check("a2_raw3", raw_a2, 8'h30);
        check("a2_avg_valid3", av_a2, 0);
        vin_a2 = 8'h41;
        tick(2048);
        check("a2_raw4", raw_a2, 8'h41);
        check("a2_raw_valid4", rv_a2, 1);
        check("a2_avg_valid4", av_a2, 1);
        check("a2_avg8", avg_a2, 8'h28);
        check("a2_mv16", mv_a2, 515);
        en_a2 = 1'b0;

        // No averaging: avg follows every conversion
        vin_a0 = 8'hFF;
        en_a0 = 1'b1;
        tick(2049);
        check("a0_avg_valid1", av_a0, 1);
        check("a0_avg8_ff", avg_a0, 8'hFF);
        check("a0_mv16_ff", mv_a0, 3287);
        vin_a0 = 8'h80;
        tick(2048);
        check("a0_avg_valid2", av_a0, 1);
        check("a0_avg8_80", avg_a0, 8'h80);
        check("a0_mv16_80", mv_a0, 1650);
        en_a0 = 1'b0;
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
